// File: rtl/arm_pkg.sv
// Shared types and helpers for the arm target scheduler: FSM states, source IDs,
// the angle type and small saturating/clamping helpers.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SOLVE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_KB   = 2'd1,
        SRC_US   = 2'd2
    } src_e;

    typedef logic [7:0] angle_t;

    localparam angle_t ANGLE_MAX = 8'd180;

    function automatic angle_t clamp_angle(input logic [7:0] raw);
        if (raw > ANGLE_MAX) begin
            return ANGLE_MAX;
        end else begin
            return raw;
        end
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/angle_slew.sv
// One joint's slew limiter: on each tick the committed angle moves toward the
// target by at most MAX_STEP degrees and lands exactly on it without overshoot.
module angle_slew
    import arm_pkg::*;
#(
    parameter int unsigned MAX_STEP = 4,
    parameter int unsigned HOME     = 90
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   tick,
    input  angle_t target,
    output angle_t angle
);

    localparam logic signed [8:0] STEP_POS = 9'(MAX_STEP);
    localparam angle_t            STEP_ANG = angle_t'(MAX_STEP);

    angle_t            angle_r;
    angle_t            next_s;
    logic signed [8:0] diff_s;

    // Signed distance to target decides between a full step and the final snap.
    always_comb begin
        diff_s = $signed({1'b0, target}) - $signed({1'b0, angle_r});
        if (diff_s > STEP_POS) begin
            next_s = angle_r + STEP_ANG;
        end else if (diff_s < -STEP_POS) begin
            next_s = angle_r - STEP_ANG;
        end else begin
            next_s = target;
        end
    end

    // Committed angle only changes on the frame tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            angle_r <= angle_t'(HOME);
        end else if (tick) begin
            angle_r <= next_s;
        end else begin
            angle_r <= angle_r;
        end
    end

    assign angle = angle_r;

endmodule

// File: rtl/arm_target_scheduler.sv
// Selects the active (x,y) target source, hands new targets to the shared IK
// solver over req/ack, and slew-limits the joint angles once per servo frame.
module arm_target_scheduler
    import arm_pkg::*;
#(
    parameter int unsigned CLKS_PER_FRAME = 2_000_000,
    parameter int unsigned MAX_STEP       = 4,
    parameter int unsigned IK_TIMEOUT     = 1024,
    parameter int unsigned HOME_SHOULDER  = 90,
    parameter int unsigned HOME_ELBOW     = 90
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyboardControlled,
    input  logic       ultrasonicControlled,
    input  logic [7:0] kb_x,
    input  logic [7:0] kb_y,
    input  logic       kb_valid,
    input  logic [7:0] us_x,
    input  logic [7:0] us_y,
    input  logic       us_valid,
    output logic       ik_req,
    output logic [7:0] ik_x,
    output logic [7:0] ik_y,
    input  logic       ik_ack,
    input  logic [7:0] ik_shoulder,
    input  logic [7:0] ik_elbow,
    input  logic       ik_error,
    output logic [7:0] shoulder_angle,
    output logic [7:0] elbow_angle,
    output logic       frame_tick,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam int unsigned    FCW          = (CLKS_PER_FRAME > 1) ? $clog2(CLKS_PER_FRAME) : 1;
    localparam int unsigned    TCW          = (IK_TIMEOUT > 1) ? $clog2(IK_TIMEOUT) : 1;
    localparam logic [FCW-1:0] FRAME_LAST   = FCW'(CLKS_PER_FRAME - 1);
    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(IK_TIMEOUT - 1);
    localparam angle_t         HOME_SH      = angle_t'(HOME_SHOULDER);
    localparam angle_t         HOME_EL      = angle_t'(HOME_ELBOW);

    state_e         state_r;
    state_e         state_s;
    src_e           sel_s;
    src_e           sel_prev_r;
    logic           sel_valid_s;
    logic [7:0]     sel_x_s;
    logic [7:0]     sel_y_s;
    logic           src_changed_s;

    logic           pend_r;
    logic [7:0]     pend_x_r;
    logic [7:0]     pend_y_r;
    src_e           pend_src_r;
    src_e           rec_src_r;

    logic [TCW-1:0] to_cnt_r;
    logic           ack_s;
    logic           timeout_s;
    logic           accept_s;
    logic           err_evt_s;

    logic           ik_req_r;
    logic [7:0]     ik_x_r;
    logic [7:0]     ik_y_r;
    logic           busy_r;
    logic [7:0]     err_r;
    angle_t         tgt_sh_r;
    angle_t         tgt_el_r;
    logic [FCW-1:0] frame_cnt_r;
    logic           tick_s;
    logic           frame_tick_r;

    // Keyboard outranks ultrasonic; only the winner's valid and operands pass through.
    always_comb begin
        sel_s       = SRC_NONE;
        sel_valid_s = 1'b0;
        sel_x_s     = 8'd0;
        sel_y_s     = 8'd0;
        if (keyboardControlled) begin
            sel_s       = SRC_KB;
            sel_valid_s = kb_valid;
            sel_x_s     = kb_x;
            sel_y_s     = kb_y;
        end else if (ultrasonicControlled) begin
            sel_s       = SRC_US;
            sel_valid_s = us_valid;
            sel_x_s     = us_x;
            sel_y_s     = us_y;
        end else begin
            sel_s       = SRC_NONE;
        end
    end

    assign src_changed_s = (sel_s != sel_prev_r);

    // A result only counts if the source that requested it is still in charge.
    always_comb begin
        ack_s     = 1'b0;
        timeout_s = 1'b0;
        accept_s  = 1'b0;
        err_evt_s = 1'b0;
        if (state_r == SOLVE) begin
            ack_s     = ik_ack;
            timeout_s = !ik_ack && (to_cnt_r == TIMEOUT_LAST);
            accept_s  = ik_ack && !ik_error && (rec_src_r == sel_s);
            err_evt_s = (ik_ack && ik_error && (rec_src_r == sel_s)) || timeout_s;
        end else begin
            ack_s     = 1'b0;
        end
    end

    // Next-state logic; a valid arriving in IDLE goes straight to LATCH.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if ((pend_r && !src_changed_s) || sel_valid_s) begin
                    state_s = LATCH;
                end else begin
                    state_s = IDLE;
                end
            end
            LATCH: state_s = SOLVE;
            SOLVE: begin
                if (ack_s || timeout_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = SOLVE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register plus the handshake outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            ik_req_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            ik_req_r <= (state_s == SOLVE);
            busy_r   <= (state_s != IDLE);
        end
    end

    // Pending buffer: newest valid wins, cleared on latch or source change.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r     <= 1'b0;
            pend_x_r   <= 8'd0;
            pend_y_r   <= 8'd0;
            pend_src_r <= SRC_NONE;
            sel_prev_r <= SRC_NONE;
        end else begin
            sel_prev_r <= sel_s;
            if (sel_valid_s) begin
                pend_r     <= 1'b1;
                pend_x_r   <= sel_x_s;
                pend_y_r   <= sel_y_s;
                pend_src_r <= sel_s;
            end else if (src_changed_s || (state_r == LATCH)) begin
                pend_r     <= 1'b0;
            end else begin
                pend_r     <= pend_r;
            end
        end
    end

    // Solver operands, requesting source and the SOLVE timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ik_x_r    <= 8'd0;
            ik_y_r    <= 8'd0;
            rec_src_r <= SRC_NONE;
            to_cnt_r  <= '0;
        end else if (state_r == LATCH) begin
            ik_x_r    <= pend_x_r;
            ik_y_r    <= pend_y_r;
            rec_src_r <= pend_src_r;
            to_cnt_r  <= '0;
        end else if (state_r == SOLVE) begin
            to_cnt_r  <= to_cnt_r + 1'b1;
        end else begin
            to_cnt_r  <= to_cnt_r;
        end
    end

    // Targets go home with no source selected, otherwise take accepted results.
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_sh_r <= HOME_SH;
            tgt_el_r <= HOME_EL;
            err_r    <= 8'd0;
        end else begin
            if (sel_s == SRC_NONE) begin
                tgt_sh_r <= HOME_SH;
                tgt_el_r <= HOME_EL;
            end else if (accept_s) begin
                tgt_sh_r <= clamp_angle(ik_shoulder);
                tgt_el_r <= clamp_angle(ik_elbow);
            end else begin
                tgt_sh_r <= tgt_sh_r;
                tgt_el_r <= tgt_el_r;
            end
            if (err_evt_s) begin
                err_r <= sat_inc(err_r);
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign tick_s = (frame_cnt_r == FRAME_LAST);

    // Free-running frame counter; frame_tick is registered alongside the angle update.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r  <= '0;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= tick_s;
            if (tick_s) begin
                frame_cnt_r <= '0;
            end else begin
                frame_cnt_r <= frame_cnt_r + 1'b1;
            end
        end
    end

    angle_slew #(
        .MAX_STEP (MAX_STEP),
        .HOME     (HOME_SHOULDER)
    ) u_slew_shoulder (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick_s),
        .target (tgt_sh_r),
        .angle  (shoulder_angle)
    );

    angle_slew #(
        .MAX_STEP (MAX_STEP),
        .HOME     (HOME_ELBOW)
    ) u_slew_elbow (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick_s),
        .target (tgt_el_r),
        .angle  (elbow_angle)
    );

    assign ik_req     = ik_req_r;
    assign ik_x       = ik_x_r;
    assign ik_y       = ik_y_r;
    assign busy       = busy_r;
    assign err_count  = err_r;
    assign frame_tick = frame_tick_r;

endmodule
